// File: rtl/esc_pwm_out.sv
// esc_pwm_out: ESC drive pulse generator with an arming sequence.
// Each frame is PERIOD_CYCLES clocks; the pulse is MIN_CYCLES plus
// duty*CYCLES_PER_STEP clocks, starting the cycle after period_start.
// Compile-time option: define ESC_PWM_RAMP_EN to slew-limit the applied
// duty by RAMP_STEP per frame while running.
module esc_pwm_out #(
    parameter int unsigned PERIOD_CYCLES   = 1000000,
    parameter int unsigned MIN_CYCLES      = 50000,
    parameter int unsigned CYCLES_PER_STEP = 50,
    parameter int unsigned ARM_PERIODS     = 100,
    parameter int unsigned RAMP_STEP       = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] ratio,
    input  logic        disarm,
    output logic        pwm_out,
    output logic        armed,
    output logic        period_start,
    output logic [10:0] duty_applied
);

    localparam int unsigned CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int unsigned ARM_W = (ARM_PERIODS > 0) ? $clog2(ARM_PERIODS + 1) : 1;
    localparam logic [10:0] DUTY_MAX  = 11'd1000;
    localparam logic [10:0] STEP      = 11'(RAMP_STEP);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(ARM_PERIODS);

`ifdef ESC_PWM_RAMP_EN
    localparam bit RAMP_ON = 1'b1;
`else
    localparam bit RAMP_ON = 1'b0;
`endif

    typedef enum logic {ARMING, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ARM_W-1:0] arm_q, arm_d;
    logic [10:0]      duty_q, duty_d;
    logic             pwm_q, pwm_d;
    logic             started_q;
    logic             boundary;
    logic [10:0]      target;
    logic [31:0]      pw_cycles;

    // started_q holds the counter at 0 through the first edge after reset,
    // so the cycle following that edge is a proper frame boundary.
    assign boundary = started_q && (cnt_q == '0);
    assign target   = (ratio > DUTY_MAX) ? DUTY_MAX : ratio;

    // Move from 'from' toward the target, bounded by STEP, landing exactly.
    function automatic logic [10:0] slew(input logic [10:0] from, input logic [10:0] to);
        logic [10:0] r;
        r = to;
        if (to > from) begin
            if ((to - from) > STEP) r = from + STEP;
        end else if ((from - to) > STEP) begin
            r = from - STEP;
        end
        return r;
    endfunction

    // Next duty for a running frame: slewed or direct depending on build.
    function automatic logic [10:0] next_duty(input logic [10:0] from, input logic [10:0] to);
        return RAMP_ON ? slew(from, to) : to;
    endfunction

    // Frame counter: wraps at PERIOD_CYCLES-1, frozen until first edge after reset.
    always_comb begin
        cnt_d = cnt_q;
        if (started_q) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Arming FSM and duty latch; duty only changes out of a boundary cycle.
    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        duty_d  = duty_q;
        if (disarm) begin
            state_d = ARMING;
            arm_d   = '0;
            if (boundary) duty_d = '0;
        end else if (boundary) begin
            case (state_q)
                ARMING: begin
                    if (arm_q == ARM_DONE) begin
                        state_d = RUN;
                        duty_d  = next_duty(11'd0, target);
                    end else begin
                        arm_d  = arm_q + ARM_W'(1);
                        duty_d = '0;
                    end
                end
                RUN:     duty_d = next_duty(duty_q, target);
                default: state_d = ARMING;
            endcase
        end
    end

    // Pulse width for the frame about to run, widened to avoid overflow.
    always_comb begin
        pw_cycles = 32'(MIN_CYCLES) + 32'(duty_d) * 32'(CYCLES_PER_STEP);
        pwm_d     = started_q && (32'(cnt_q) < pw_cycles);
    end

    // State registers; reset clears everything, including a pulse in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q <= 1'b0;
            cnt_q     <= '0;
            arm_q     <= '0;
            state_q   <= ARMING;
            duty_q    <= '0;
            pwm_q     <= 1'b0;
        end else begin
            started_q <= 1'b1;
            cnt_q     <= cnt_d;
            arm_q     <= arm_d;
            state_q   <= state_d;
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign armed        = (state_q == RUN);
    assign period_start = boundary;
    assign duty_applied = duty_q;

endmodule

// File: tb/tb_esc_pwm_out.sv
// Bench for esc_pwm_out: random ratio stimulus against a frame-level model.
module tb_esc_pwm_out;
    localparam int P     = 1100;
    localparam int MINC  = 40;
    localparam int CPS   = 1;
    localparam int ARM   = 4;
    localparam int RSTEP = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] ratio = 11'd500;
    logic        disarm = 1'b0;
    logic        pwm_out, armed, period_start;
    logic [10:0] duty_applied;

    esc_pwm_out #(
        .PERIOD_CYCLES(P), .MIN_CYCLES(MINC), .CYCLES_PER_STEP(CPS),
        .ARM_PERIODS(ARM), .RAMP_STEP(RSTEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ratio(ratio), .disarm(disarm),
        .pwm_out(pwm_out), .armed(armed), .period_start(period_start),
        .duty_applied(duty_applied)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: frames counted while arming, armed flag, duty of the frame
    int m_arm = 0;
    bit m_armed = 0;
    int m_duty = 0;
    // monitor state
    bit mon_ps = 0;
    bit have_frame = 0;
    bit shape_ok = 1;
    bit ps_lost = 0;
    int pos = 0;
    int hi = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ramp(input int cur, input int tgt);
`ifdef ESC_PWM_RAMP_EN
        if (tgt > cur + RSTEP) return cur + RSTEP;
        if (tgt < cur - RSTEP) return cur - RSTEP;
        return tgt;
`else
        return tgt + 0 * cur;
`endif
    endfunction

    // Frame-boundary rule: what the next frame's duty and arm status are.
    task automatic model_boundary(input int r, input bit d);
        int tgt;
        tgt = (r > 1000) ? 1000 : r;
        if (d) begin
            m_arm = 0; m_armed = 0; m_duty = 0;
        end else if (!m_armed) begin
            if (m_arm == ARM) begin
                m_armed = 1;
                m_duty  = ramp(0, tgt);
            end else begin
                m_arm++;
                m_duty = 0;
            end
        end else begin
            m_duty = ramp(m_duty, tgt);
        end
    endtask

    function automatic logic [10:0] pick();
        case ($urandom_range(0, 7))
            0: return 11'd0;
            1: return 11'd1000;
            2: return 11'd1001;
            3: return 11'd2047;
            4: return 11'd999;
            5: return 11'd1;
            default: return 11'($urandom_range(0, 2047));
        endcase
    endfunction

    // One clock: update the model for the edge, then observe the DUT.
    task automatic tick();
        bit d_now;
        d_now = disarm;
        if (mon_ps) model_boundary(int'(ratio), disarm);
        else if (disarm) begin m_arm = 0; m_armed = 0; end
        @(posedge clk); #1;
        if (d_now) chk("armed_drop", {31'd0, armed}, 32'd0);
        if (period_start) begin
            if (have_frame) begin
                chk("frame_len", pos + 1, P);
                chk("pulse_w", hi, MINC + m_duty * CPS);
                chk("pulse_shape", {31'd0, shape_ok}, 32'd1);
            end
            have_frame = 1; pos = 0; hi = 0; shape_ok = 1; ps_lost = 0;
        end else begin
            pos++;
            if (pos > P && !ps_lost) begin
                chk("ps_timeout", pos, P);
                ps_lost = 1;
            end
        end
        if (pwm_out) begin
            if (pos != hi + 1) shape_ok = 0;
            hi++;
        end
        if (have_frame && (pos == 1 || pos == P / 2)) begin
            chk("duty", {21'd0, duty_applied}, m_duty);
            chk("armed", {31'd0, armed}, {31'd0, m_armed});
        end
        mon_ps = period_start;
    endtask

    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd && $urandom_range(0, 299) == 0) ratio = pick();
            tick();
        end
    endtask

    task automatic wait_pos(input int target);
        for (int i = 0; i < 2 * P; i++) begin
            if (have_frame && pos == target) break;
            tick();
        end
        chk("reach_pos", pos, target);
    endtask

    task automatic check_reset_outputs();
        chk("rst_pwm", {31'd0, pwm_out}, 32'd0);
        chk("rst_armed", {31'd0, armed}, 32'd0);
        chk("rst_ps", {31'd0, period_start}, 32'd0);
        chk("rst_duty", {21'd0, duty_applied}, 32'd0);
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        m_arm = 0; m_armed = 0; m_duty = 0;
        mon_ps = 0; have_frame = 0; pos = 0; hi = 0;
        tick();
        chk("first_ps", {31'd0, period_start}, 32'd1);
        chk("first_duty", {21'd0, duty_applied}, 32'd0);
    endtask

    initial begin
        #2;
        check_reset_outputs();
        release_reset();

        // arming with a fixed command, then armed at the expected frame
        run((ARM + 1) * P + 5, 1'b0);
        chk("armed_after_arm", {31'd0, armed}, 32'd1);

        // random commands, changing at arbitrary points within frames
        run(12 * P, 1'b1);

        // single-cycle disarm mid-frame, then re-arm
        wait_pos(P / 3);
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        run(7 * P, 1'b1);

        // disarm raised in a boundary cycle and held across frames
        wait_pos(0);
        disarm = 1'b1;
        run(2 * P + 5, 1'b0);
        disarm = 1'b0;
        run(7 * P, 1'b1);

        // reset in the middle of a pulse
        ratio = 11'd1000;
        wait_pos(20);
        chk("pwm_before_rst", {31'd0, pwm_out}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        release_reset();
        run(3 * P, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
